// File: rtl/snn_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : snn_pkg                                                       |
// | Brief    : Shared types and sizes for the image loader and snn_core.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package snn_pkg;

    localparam int NUM_INPUT_BITS = 784;
    localparam int IMG_ADDR_W     = 10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT     = 3'd1,
        WAIT_BYTE = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/image_loader_byte_serializer.sv
// +--------------------------------------------------------------------------+
// | Module   : byte_serializer                                               |
// | Brief    : 8-bit LSB-first shift register with a bit index.              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module byte_serializer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] din,
    output logic       bit_out,
    output logic       last_bit
);

    logic [7:0] r_shreg;
    logic [2:0] r_bit_idx;

    // load wins over shift so a new byte always starts at bit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_bit_idx <= '0;
        end else if (load) begin
            r_shreg   <= din;
            r_bit_idx <= '0;
        end else if (shift) begin
            r_shreg   <= {1'b0, r_shreg[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
        end
    end

    assign bit_out  = r_shreg[0];
    assign last_bit = (r_bit_idx == 3'd7);

endmodule

`default_nettype wire

// File: rtl/image_loader.sv
// +--------------------------------------------------------------------------+
// | Module   : image_loader                                                  |
// | Brief    : Unpacks UART bytes into the 1-bit image RAM, starts snn_core. |
// |            Optional inter-byte timeout: IMAGE_LOADER_TIMEOUT_EN.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module image_loader
    import snn_pkg::*;
#(
    parameter int NUM_BITS       = NUM_INPUT_BITS,
    parameter int ADDR_W         = IMG_ADDR_W,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic              snn_done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_data,
    output logic              snn_start,
    output logic              busy,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUM_BITS - 1);

    loader_state_t     r_state;
    loader_state_t     w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_overrun;
    logic              w_load;
    logic              w_shift;
    logic              w_drop;
    logic              w_timeout;
    logic              w_bit;
    logic              w_last_bit;

    byte_serializer u_serializer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .shift    (w_shift),
        .din      (rx_data),
        .bit_out  (w_bit),
        .last_bit (w_last_bit)
    );

`ifdef IMAGE_LOADER_TIMEOUT_EN
    localparam int                 c_TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(TIMEOUT_CYCLES);

    logic [c_TMO_W-1:0] r_tmo_cnt;

    // Counts only while parked in WAIT_BYTE; any state change restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == WAIT_BYTE && w_state_nxt == WAIT_BYTE) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == WAIT_BYTE) && (r_tmo_cnt == c_TMO_MAX);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_overrun <= w_drop || (w_timeout && !rx_rdy);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_rdy) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_shift    = 1'b1;
                w_drop     = rx_rdy;
                w_addr_nxt = r_addr + 1'b1;
                // The final image bit ends the byte early; leftover bits are discarded
                if (r_addr == c_LAST_ADDR) begin
                    w_state_nxt = START;
                end else if (w_last_bit) begin
                    w_state_nxt = WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                // A byte arriving on the timeout cycle is kept rather than lost
                if (rx_rdy) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end else if (w_timeout) begin
                    w_addr_nxt  = '0;
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                w_drop      = rx_rdy;
                w_addr_nxt  = '0;
                w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                w_drop = rx_rdy;
                if (snn_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ram_we    = (r_state == SHIFT);
    assign ram_addr  = r_addr;
    assign ram_data  = (r_state == SHIFT) && w_bit;
    assign snn_start = (r_state == START);
    assign busy      = (r_state != IDLE);
    assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_image_loader.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_image_loader                                               |
// | Brief    : Self-checking bench for image_loader (three configurations).  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_image_loader;

    logic clk;
    logic rst_n;

    // Instance A: default build
    logic       a_rx_rdy, a_snn_done;
    logic [7:0] a_rx_data;
    logic       a_ram_we, a_ram_data, a_snn_start, a_busy, a_overrun;
    logic [9:0] a_ram_addr;

    // Instance B: 12-bit image
    logic       b_rx_rdy, b_snn_done;
    logic [7:0] b_rx_data;
    logic       b_ram_we, b_ram_data, b_snn_start, b_busy, b_overrun;
    logic [3:0] b_ram_addr;

    // Instance C: short inter-byte timeout
    logic       c_rx_rdy, c_snn_done;
    logic [7:0] c_rx_data;
    logic       c_ram_we, c_ram_data, c_snn_start, c_busy, c_overrun;
    logic [9:0] c_ram_addr;

    image_loader u_dut_a (
        .clk(clk), .rst_n(rst_n), .rx_rdy(a_rx_rdy), .rx_data(a_rx_data),
        .snn_done(a_snn_done), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
        .ram_data(a_ram_data), .snn_start(a_snn_start), .busy(a_busy),
        .overrun(a_overrun)
    );

    image_loader #(.NUM_BITS(12), .ADDR_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rx_rdy(b_rx_rdy), .rx_data(b_rx_data),
        .snn_done(b_snn_done), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
        .ram_data(b_ram_data), .snn_start(b_snn_start), .busy(b_busy),
        .overrun(b_overrun)
    );

    image_loader #(.TIMEOUT_CYCLES(100)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .rx_rdy(c_rx_rdy), .rx_data(c_rx_data),
        .snn_done(c_snn_done), .ram_we(c_ram_we), .ram_addr(c_ram_addr),
        .ram_data(c_ram_data), .snn_start(c_snn_start), .busy(c_busy),
        .overrun(c_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {addr, data} of every A write, in order
    logic [10:0] sb[$];
    int          m_addr;

    int ncyc = 0;
    int a_rdy_n, a_start_n, a_start_cnt = 0, a_ovr_cnt = 0, a_we_cnt = 0;
    int b_w11_n = -1, b_start_n = -1, b_start_cnt = 0;
    logic [15:0] b_mask = '0;
    logic [15:0] b_val  = '0;
    int   c_ovr_cnt = 0;
    logic c_arm = 1'b0;
    int   c_first_addr = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (a_rx_rdy)    a_rdy_n = ncyc;
            if (a_snn_start) begin a_start_cnt++; a_start_n = ncyc; end
            if (a_overrun)   a_ovr_cnt++;
            if (a_ram_we) begin
                a_we_cnt++;
                chk("a_write_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("a_write", {a_ram_addr, a_ram_data}, e);
                end
            end
            if (b_ram_we) begin
                b_mask[b_ram_addr] = 1'b1;
                b_val[b_ram_addr]  = b_ram_data;
                if (b_ram_addr == 4'd11) b_w11_n = ncyc;
            end
            if (b_snn_start) begin b_start_cnt++; b_start_n = ncyc; end
            if (c_overrun) c_ovr_cnt++;
            if (c_ram_we && c_arm) begin
                c_first_addr = int'(c_ram_addr);
                c_arm = 1'b0;
            end
        end
    end

    task automatic send_a(input logic [7:0] b, input bit acc, input int gap);
        @(posedge clk); #1;
        a_rx_rdy = 1'b1; a_rx_data = b;
        if (acc) begin
            for (int i = 0; i < 8; i++) begin
                if (m_addr < 784) begin
                    sb.push_back({m_addr[9:0], b[i]});
                    m_addr++;
                end
            end
            if (m_addr == 784) m_addr = 0;
        end
        @(posedge clk); #1;
        a_rx_rdy = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic done_a();
        @(posedge clk); #1; a_snn_done = 1'b1;
        @(posedge clk); #1; a_snn_done = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b, input int gap);
        @(posedge clk); #1; b_rx_rdy = 1'b1; b_rx_data = b;
        @(posedge clk); #1; b_rx_rdy = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_c(input logic [7:0] b, input int gap);
        @(posedge clk); #1; c_rx_rdy = 1'b1; c_rx_data = b;
        @(posedge clk); #1; c_rx_rdy = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        a_rx_rdy = 0; a_rx_data = 0; a_snn_done = 0;
        b_rx_rdy = 0; b_rx_data = 0; b_snn_done = 0;
        c_rx_rdy = 0; c_rx_data = 0; c_snn_done = 0;
        m_addr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs_a", {a_ram_we, a_ram_addr, a_ram_data, a_snn_start, a_busy, a_overrun}, 32'd0);
        chk("reset_busy_bc", {b_busy, c_busy, b_ram_we, c_ram_we}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full image of 0xA5 bytes
        for (int k = 0; k < 98; k++) send_a(8'hA5, 1'b1, 12);
        chk("img1_we_cnt", a_we_cnt, 784);
        chk("img1_start_cnt", a_start_cnt, 1);
        chk("img1_latency", a_start_n - a_rdy_n, 9);
        chk("img1_sb_empty", sb.size(), 0);
        @(negedge clk);
        chk("img1_busy_wait_done", {a_busy, a_ram_we}, 2'b10);
        done_a();
        @(negedge clk);
        chk("img1_idle_after_done", a_busy, 1'b0);

        // Second rx_rdy while shifting is dropped
        @(posedge clk); #1;
        a_rx_rdy = 1'b1; a_rx_data = 8'h3C;
        for (int i = 0; i < 8; i++) begin sb.push_back({m_addr[9:0], a_rx_data[i]}); m_addr++; end
        @(posedge clk); #1;
        a_rx_data = 8'hFF;
        @(posedge clk); #1;
        a_rx_rdy = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("ovr_shift_cnt", a_ovr_cnt, 1);
        chk("ovr_shift_addr", a_ram_addr, 10'd8);
        chk("ovr_shift_sb_empty", sb.size(), 0);

        for (int k = 1; k < 98; k++) send_a(8'(k * 37 + 11), 1'b1, 12);
        chk("img2_start_cnt", a_start_cnt, 2);
        chk("img2_we_cnt", a_we_cnt, 1568);

        // Bytes during WAIT_DONE are dropped
        for (int k = 0; k < 5; k++) send_a(8'hFF, 1'b0, 3);
        chk("wait_done_ovr_cnt", a_ovr_cnt, 6);
        chk("wait_done_no_we", a_we_cnt, 1568);
        done_a();
        send_a(8'h81, 1'b1, 12);
        chk("rearm_sb_empty", sb.size(), 0);

        // Reset part-way through an image
        for (int k = 1; k < 40; k++) send_a(8'(k * 13), 1'b1, 12);
        chk("pre_reset_we_cnt", a_we_cnt, 1888);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_outs_a", {a_ram_we, a_ram_addr, a_ram_data, a_snn_start, a_busy, a_overrun}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_addr = 0;
        for (int k = 0; k < 98; k++) send_a(8'hC3, 1'b1, 12);
        chk("img3_start_cnt", a_start_cnt, 3);
        chk("img3_we_cnt", a_we_cnt, 2672);
        chk("img3_latency", a_start_n - a_rdy_n, 9);
        chk("img3_sb_empty", sb.size(), 0);

        // NUM_BITS=12: partial final byte
        send_b(8'hFF, 12);
        send_b(8'h0F, 12);
        chk("b_written_mask", b_mask, 16'h0FFF);
        chk("b_written_val", b_val & 16'h0FFF, 16'h0FFF);
        chk("b_start_cnt", b_start_cnt, 1);
        chk("b_start_after_w11", b_start_n - b_w11_n, 1);

        // Inter-byte gap longer than the timeout
        send_c(8'h01, 12);
        send_c(8'h01, 12);
        send_c(8'h01, 130);
        c_arm = 1'b1;
        send_c(8'hFF, 12);
`ifdef IMAGE_LOADER_TIMEOUT_EN
        chk("c_timeout_ovr", c_ovr_cnt, 1);
        chk("c_first_addr", c_first_addr, 0);
`else
        chk("c_timeout_ovr", c_ovr_cnt, 0);
        chk("c_first_addr", c_first_addr, 24);
`endif

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
